// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl download to SDRAM write loader.
package ioctl_loader_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned WORD_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic word_t swap_bytes(input word_t w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of address/data entries; pushes when full and pops
// when empty are ignored.
module loader_fifo
    import ioctl_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Buffers HPS ioctl download words and drains them as SDRAM write requests.
// Define IOCTL_LOADER_CHECKSUM_EN to add a 16-bit checksum of acknowledged words.
module ioctl_sdram_loader
    import ioctl_loader_pkg::*;
#(
    parameter logic [7:0]  INDEX = 8'h00,
    parameter addr_t       BASE  = 25'h0,
    parameter bit          SWAP  = 1'b1,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    output logic        hold,
    output logic        done,
    output logic        overflow
`ifdef IOCTL_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_active;
    logic          r_wait;
    logic          r_hold;
    logic          r_done;
    logic          r_overflow;
    logic          r_mem_req;
    addr_t         r_mem_addr;
    word_t         r_mem_wdata;

    logic          w_active_next;
    logic          w_act_rise;
    logic          w_accept;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_hold_next;
    entry_t        w_fifo_din;
    entry_t        w_fifo_dout;
    logic          w_unused_addr0;

    // Once latched, the session ignores index changes until download falls.
    assign w_active_next = ioctl_download & (r_active | (ioctl_index == INDEX));
    assign w_act_rise    = w_active_next & ~r_active;

    assign w_accept = r_active & ioctl_wr;
    assign w_push   = w_accept & ~w_full;
    assign w_drop   = w_accept & w_full;

    assign w_fifo_din.addr = BASE + {ioctl_addr[24:1], 1'b0};
    assign w_fifo_din.data = SWAP ? swap_bytes(ioctl_dout) : ioctl_dout;
    assign w_unused_addr0  = ioctl_addr[0];

    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    assign w_hold_next  = w_active_next | (w_count_next != '0) | (w_state_next == REQ);

    loader_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain: one request per word, with a mandatory idle cycle after each ack.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_active    <= 1'b0;
            r_wait      <= 1'b0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_active <= w_active_next;
            r_wait   <= (w_count_next >= CW'(DEPTH - 1));
            r_hold   <= w_hold_next;
            r_done   <= r_hold & ~w_hold_next;
            if (w_act_rise) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_mem_req <= (w_state_next == REQ);
            if (w_pop) begin
                r_mem_addr  <= w_fifo_dout.addr;
                r_mem_wdata <= w_fifo_dout.data;
            end
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // A new session restarts the sum even if an old word completes that cycle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_act_rise) begin
            r_checksum <= '0;
        end else if ((r_state == REQ) && mem_ack) begin
            r_checksum <= r_checksum + r_mem_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

    assign ioctl_wait = r_wait;
    assign hold       = r_hold;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Bench for ioctl_sdram_loader: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ioctl_sdram_loader;

    localparam logic [7:0]  P_INDEX = 8'h00;
    localparam logic [24:0] P_BASE  = 25'h1000000;
    localparam bit          P_SWAP  = 1'b1;
    localparam int unsigned P_DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        hold;
    logic        done;
    logic        overflow;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_sdram_loader #(
        .INDEX (P_INDEX),
        .BASE  (P_BASE),
        .SWAP  (P_SWAP),
        .DEPTH (P_DEPTH)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .hold           (hold),
        .done           (done),
        .overflow       (overflow)
`ifdef IOCTL_LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: a word queue plus the single word currently on the bus.
    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_cur;
    bit          m_busy, m_act, m_ovf, m_hold, e_wait, e_done;
    logic [15:0] m_cs;
    int          n_ack  = 0;
    int          n_done = 0;

    task automatic model_clear();
        m_q.delete();
        m_cur  = '{a: '0, d: '0};
        m_busy = 0; m_act = 0; m_ovf = 0; m_hold = 0; e_wait = 0; e_done = 0;
        m_cs   = '0;
    endtask

    task automatic model_step();
        int   pre_n;
        bit   act_n;
        ent_t e;
        pre_n = m_q.size();
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                m_cs   = m_cs + m_cur.d;
                n_ack++;
            end
        end else if (pre_n > 0) begin
            m_cur  = m_q.pop_front();
            m_busy = 1;
        end
        if (m_act && ioctl_wr) begin
            if (pre_n == P_DEPTH) m_ovf = 1;
            else begin
                e.a = P_BASE + {ioctl_addr[24:1], 1'b0};
                e.d = P_SWAP ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
                m_q.push_back(e);
            end
        end
        act_n = ioctl_download && (m_act || ioctl_index == P_INDEX);
        if (act_n && !m_act) begin
            m_ovf = 0;
            m_cs  = '0;
        end
        m_act  = act_n;
        e_wait = (m_q.size() >= P_DEPTH - 1);
        e_done = m_hold && !(m_act || m_q.size() > 0 || m_busy);
        m_hold = m_act || m_q.size() > 0 || m_busy;
    endtask

    always @(posedge clk_sys) begin
        if (reset) model_clear();
        else model_step();
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_cur.a));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_cur.d));
        end
        chk("ioctl_wait", 32'(ioctl_wait), 32'(e_wait));
        chk("hold", 32'(hold), 32'(m_hold));
        chk("done", 32'(done), 32'(e_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef IOCTL_LOADER_CHECKSUM_EN
        if (e_done) chk("checksum", 32'(checksum), 32'(m_cs));
`endif
        if (done) n_done++;
    end

    task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        chk("req_timeout", 32'(mem_req), 32'd1);
    endtask

    task automatic ack_pulse();
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        while (hold && k < 300) begin
            mem_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_sys);
            k++;
        end
        mem_ack = 1'b0;
        chk("drain_timeout", 32'(hold), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ack        = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);

        // Single word: one-cycle latency to request, byte swap, done on hold fall
        ioctl_download = 1'b1;
        ioctl_index    = P_INDEX;
        repeat (2) @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = 25'h000010; ioctl_dout = 16'h1234;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(posedge clk_sys);
        #2;
        chk("single_req", 32'(mem_req), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'h1000010);
        chk("single_data", 32'(mem_wdata), 32'h3412);
        @(negedge clk_sys);
        ack_pulse();
        chk("single_ack_drop", 32'(mem_req), 32'd0);
        ioctl_download = 1'b0;
        d0 = n_done;
        repeat (4) @(negedge clk_sys);
        chk("single_hold_low", 32'(hold), 32'd0);
        chk("single_done_cnt", 32'(n_done - d0), 32'd1);

        // Back-pressure then overflow with the drain stalled
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        a0 = n_ack;
        wr_word(25'h0, 16'h0001);
        wr_word(25'h2, 16'h0002);
        wr_word(25'h4, 16'h0003);
        chk("bp_wait_cnt2", 32'(ioctl_wait), 32'd0);
        wr_word(25'h6, 16'h0004);
        chk("bp_wait_cnt3", 32'(ioctl_wait), 32'd1);
        wr_word(25'h8, 16'h0005);
        chk("bp_no_ovf", 32'(overflow), 32'd0);
        wr_word(25'hA, 16'hBEEF);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            wait_req();
            chk("bp_order_addr", 32'(mem_addr), 32'(P_BASE + 25'(2 * (k - 1))));
            chk("bp_order_data", 32'(mem_wdata), 32'({8'(k), 8'h00}));
            ack_pulse();
        end
        ioctl_download = 1'b0;
        drain(1'b0);
        chk("bp_ack_cnt", 32'(n_ack - a0), 32'd5);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Index filter
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int k = 0; k < 4; k++) wr_word(25'(2 * k), 16'(k + 16'h10));
        @(negedge clk_sys);
        chk("filt_req", 32'(mem_req), 32'd0);
        chk("filt_hold", 32'(hold), 32'd0);
        chk("filt_wait", 32'(ioctl_wait), 32'd0);
        ioctl_download = 1'b0;
        ioctl_index    = P_INDEX;
        @(negedge clk_sys);

        // Address wrap modulo 2^25
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("ovf_clear_on_rise", 32'(overflow), 32'd0);
        wr_word(25'h1FFFFFF, 16'hFFFF);
        wr_word(25'h0000002, 16'h0002);
        wait_req();
        chk("wrap_addr0", 32'(mem_addr), 32'h0FFFFFE);
        chk("wrap_data0", 32'(mem_wdata), 32'hFFFF);
        ack_pulse();
        wait_req();
        chk("wrap_addr1", 32'(mem_addr), 32'h1000002);
        chk("wrap_data1", 32'(mem_wdata), 32'h0200);
        ack_pulse();
        ioctl_download = 1'b0;
        drain(1'b0);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        chk("wrap_checksum", 32'(checksum), 32'h01FF);
`endif

        // Asynchronous reset in the middle of a request
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        wr_word(25'h20, 16'h5555);
        wait_req();
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_hold", 32'(hold), 32'd0);
        chk("arst_wait", 32'(ioctl_wait), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("arst_no_req", 32'(mem_req), 32'd0);

        // Randomized sessions, including overlap with a still-draining load
        for (int it = 0; it < 40; it++) begin
            int nw, written, cyc;
            ioctl_index    = ($urandom_range(0, 5) == 0) ? 8'h01 : P_INDEX;
            ioctl_download = 1'b1;
            nw      = $urandom_range(0, 12);
            written = 0;
            cyc     = 0;
            while (written < nw && cyc < 150) begin
                mem_ack = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) ioctl_index = 8'($urandom_range(0, 2));
                if ($urandom_range(0, 2) != 0 && (!ioctl_wait || $urandom_range(0, 5) == 0)) begin
                    ioctl_wr   = 1'b1;
                    ioctl_addr = 25'($urandom());
                    ioctl_dout = 16'($urandom());
                    written++;
                end else begin
                    ioctl_wr = 1'b0;
                end
                @(negedge clk_sys);
                cyc++;
            end
            ioctl_wr       = 1'b0;
            ioctl_download = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk_sys);
            end
            if ($urandom_range(0, 1) == 1) drain(1'b1);
        end
        ioctl_download = 1'b0;
        drain(1'b1);
        repeat (2) @(negedge clk_sys);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
